// File: rtl/pipeline_controller.sv
// Stall/bubble sequencer for the five-stage pipeline: load-use bubbles, memory freezes, halt drain.
// Optional stalled-cycle counter enabled by defining PIPE_STALL_COUNTER_EN.
//
// state  | meaning
// RUN    | normal issue; load-use bubble or memory freeze as needed
// DRAIN  | fetch held, NOPs injected while in-flight work retires
// HALTED | all stage registers held until resume

module pipeline_controller #(
  parameter int         DRAIN_CYCLES = 4,
  parameter logic [1:0] LOAD_SELECT  = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] id_instr,
  input  logic        exe_GPR_we,
  input  logic [4:0]  exe_GPR_waddr,
  input  logic [1:0]  exe_GPR_wdata_select,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_ena,
  output logic        if_id_ena,
  output logic        id_exe_ena,
  output logic        exe_mem_ena,
  output logic        mem_wb_ena,
  output logic        id_bubble,
  output logic        halted,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       lu;
  logic       mem_wait;
  logic       unused_instr_bits;

  assign id_rs = id_instr[25:21];
  assign id_rt = id_instr[20:16];
  assign unused_instr_bits = ^{id_instr[31:26], id_instr[15:0]};

  assign lu = exe_GPR_we
            & (exe_GPR_wdata_select == LOAD_SELECT)
            & (exe_GPR_waddr != 5'd0)
            & ((exe_GPR_waddr == id_rs) | (exe_GPR_waddr == id_rt));

  assign mem_wait = mem_req & ~mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    pc_ena      = 1'b1;
    if_id_ena   = 1'b1;
    id_exe_ena  = 1'b1;
    exe_mem_ena = 1'b1;
    mem_wb_ena  = 1'b1;
    id_bubble   = 1'b0;
    halted      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (mem_wait) begin
          // a halt request arriving during a freeze is dropped
          pc_ena      = 1'b0;
          if_id_ena   = 1'b0;
          id_exe_ena  = 1'b0;
          exe_mem_ena = 1'b0;
          mem_wb_ena  = 1'b0;
        end else begin
          if (lu) begin
            pc_ena    = 1'b0;
            if_id_ena = 1'b0;
            id_bubble = 1'b1;
          end
          if (halt_req) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end

      ST_DRAIN: begin
        pc_ena    = 1'b0;
        if_id_ena = 1'b0;
        if (mem_wait) begin
          id_exe_ena  = 1'b0;
          exe_mem_ena = 1'b0;
          mem_wb_ena  = 1'b0;
        end else begin
          id_bubble = 1'b1;
          if (drain_cnt_q == 4'd0) begin
            state_d = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q - 4'd1;
          end
        end
      end

      ST_HALTED: begin
        pc_ena      = 1'b0;
        if_id_ena   = 1'b0;
        id_exe_ena  = 1'b0;
        exe_mem_ena = 1'b0;
        mem_wb_ena  = 1'b0;
        halted      = 1'b1;
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = 4'd0;
      end
    endcase
  end

`ifdef PIPE_STALL_COUNTER_EN
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_ena && (state_q != ST_HALTED)) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: hazards, freezes, halt/drain/resume, async reset.

module tb_pipeline_controller;

  logic        clk;
  logic        reset;
  logic [31:0] id_instr;
  logic        exe_GPR_we;
  logic [4:0]  exe_GPR_waddr;
  logic [1:0]  exe_GPR_wdata_select;
  logic        mem_req;
  logic        mem_ready;
  logic        halt_req;
  logic        resume;
  logic        pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena;
  logic        id_bubble;
  logic        halted;
  logic [31:0] stall_count;

  int checks;
  int failures;
  int exp_stalls;

  // {pc, if_id, id_exe, exe_mem, mem_wb, bubble, halted}
  localparam logic [6:0] S_RUN = 7'b1111100;
  localparam logic [6:0] S_BUB = 7'b0011110;
  localparam logic [6:0] S_FRZ = 7'b0000000;
  localparam logic [6:0] S_HLT = 7'b0000001;

  logic [6:0] status;
  assign status = {pc_ena, if_id_ena, id_exe_ena, exe_mem_ena, mem_wb_ena, id_bubble, halted};

  pipeline_controller dut (
    .clk                  (clk),
    .reset                (reset),
    .id_instr             (id_instr),
    .exe_GPR_we           (exe_GPR_we),
    .exe_GPR_waddr        (exe_GPR_waddr),
    .exe_GPR_wdata_select (exe_GPR_wdata_select),
    .mem_req              (mem_req),
    .mem_ready            (mem_ready),
    .halt_req             (halt_req),
    .resume               (resume),
    .pc_ena               (pc_ena),
    .if_id_ena            (if_id_ena),
    .id_exe_ena           (id_exe_ena),
    .exe_mem_ena          (exe_mem_ena),
    .mem_wb_ena           (mem_wb_ena),
    .id_bubble            (id_bubble),
    .halted               (halted),
    .stall_count          (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs are set just after a negedge; outputs are checked 1 ns later,
  // then the following posedge is consumed and we return at the next negedge.
  task automatic cyc(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {25'd0, status}, {25'd0, exp});
    if (!exp[6] && !exp[0]) exp_stalls++;
    @(negedge clk);
  endtask

  function automatic logic [31:0] r_instr(input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, 5'd1, 11'h020};
  endfunction

  task automatic quiet();
    id_instr             = r_instr(5'd1, 5'd2);
    exe_GPR_we           = 1'b0;
    exe_GPR_waddr        = 5'd0;
    exe_GPR_wdata_select = 2'b00;
    mem_req              = 1'b0;
    mem_ready            = 1'b0;
    halt_req             = 1'b0;
    resume               = 1'b0;
  endtask

  task automatic exe_load(input logic [4:0] waddr);
    exe_GPR_we           = 1'b1;
    exe_GPR_waddr        = waddr;
    exe_GPR_wdata_select = 2'b01;
  endtask

  function automatic logic [31:0] exp_count();
`ifdef PIPE_STALL_COUNTER_EN
    return exp_stalls;
`else
    return 32'h0;
`endif
  endfunction

  initial begin
    checks     = 0;
    failures   = 0;
    exp_stalls = 0;
    quiet();
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_status", {25'd0, status}, {25'd0, S_RUN});
    chk("reset_count", stall_count, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    cyc("idle_run", S_RUN);

    // load-use on rs
    exe_load(5'd8); id_instr = r_instr(5'd8, 5'd3);
    cyc("lu_rs", S_BUB);
    exe_GPR_we = 1'b1; exe_GPR_waddr = 5'd1; exe_GPR_wdata_select = 2'b00; id_instr = r_instr(5'd4, 5'd5);
    cyc("lu_after", S_RUN);
    // load-use on rt
    exe_load(5'd9); id_instr = r_instr(5'd4, 5'd9);
    cyc("lu_rt", S_BUB);
    // back-to-back load creates a second hazard
    exe_load(5'd11); id_instr = r_instr(5'd11, 5'd0);
    cyc("lu_b2b", S_BUB);
    // r0 destination never hazards
    exe_load(5'd0); id_instr = r_instr(5'd0, 5'd0);
    cyc("lu_r0", S_RUN);
    // non-load write-back source
    exe_load(5'd8); exe_GPR_wdata_select = 2'b00; id_instr = r_instr(5'd8, 5'd8);
    cyc("lu_alu_src", S_RUN);
    exe_load(5'd8); exe_GPR_we = 1'b0;
    cyc("lu_no_we", S_RUN);

    // memory wait with a concurrent load-use: freeze wins, bubble afterwards
    exe_load(5'd8); id_instr = r_instr(5'd8, 5'd2);
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc("mw_lu_0", S_FRZ);
    cyc("mw_lu_1", S_FRZ);
    cyc("mw_lu_2", S_FRZ);
    mem_ready = 1'b1;
    cyc("mw_done_bub", S_BUB);
    quiet();
    cyc("mw_clear", S_RUN);
    chk("count_mid", stall_count, exp_count());

    // halt and drain
    halt_req = 1'b1;
    cyc("halt_req_cyc", S_RUN);
    halt_req = 1'b0;
    cyc("drain_0", S_BUB);
    halt_req = 1'b1;
    cyc("drain_1", S_BUB);
    halt_req = 1'b0;
    cyc("drain_2", S_BUB);
    cyc("drain_3", S_BUB);
    cyc("halted_0", S_HLT);
    halt_req = 1'b1;
    cyc("halted_ign", S_HLT);
    halt_req = 1'b0; resume = 1'b1;
    cyc("resume_cyc", S_HLT);
    resume = 1'b0;
    cyc("resumed", S_RUN);
    resume = 1'b1;
    cyc("resume_ign", S_RUN);
    resume = 1'b0;
    chk("count_halt", stall_count, exp_count());

    // memory wait in the middle of a drain delays halt by its length
    halt_req = 1'b1;
    cyc("h2_req", S_RUN);
    halt_req = 1'b0;
    cyc("h2_drain_0", S_BUB);
    cyc("h2_drain_1", S_BUB);
    mem_req = 1'b1; mem_ready = 1'b0;
    cyc("h2_wait_0", S_FRZ);
    cyc("h2_wait_1", S_FRZ);
    mem_req = 1'b0;
    cyc("h2_drain_2", S_BUB);
    cyc("h2_drain_3", S_BUB);
    cyc("h2_halted", S_HLT);
    chk("count_drain_wait", stall_count, exp_count());

    // async reset from HALTED, no clock edge needed
    #2;
    reset = 1'b0;
    exp_stalls = 0;
    #1;
    chk("async_rst_status", {25'd0, status}, {25'd0, S_RUN});
    chk("async_rst_count", stall_count, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc("post_rst", S_RUN);

    // halt request coincident with a load-use: bubble now, drain follows
    exe_load(5'd7); id_instr = r_instr(5'd7, 5'd1); halt_req = 1'b1;
    cyc("hlu_bub", S_BUB);
    quiet();
    cyc("hlu_drain_0", S_BUB);
    cyc("hlu_drain_1", S_BUB);
    cyc("hlu_drain_2", S_BUB);
    cyc("hlu_drain_3", S_BUB);
    cyc("hlu_halted", S_HLT);
    chk("count_final", stall_count, exp_count());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
